// File: rtl/bram_arb_pkg.sv
// Shared types and defaults for the CSR-graph BRAM read-port arbiter.
package bram_arb_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 32;
  localparam int TAG_ID_W   = 8;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } arb_state_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  always_comb begin
    int               j;
    logic [IDX_W-1:0] j_idx;
    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      j_idx = IDX_W'(j);
      if (!any && req[j_idx]) begin
        any           = 1'b1;
        onehot[j_idx] = 1'b1;
        index         = j_idx;
      end
    end
  end

endmodule

// File: rtl/bram_read_arbiter.sv
// Round-robin sharing of one BRAM read port with tagged, fixed-latency returns and a flush/drain handshake.
// Optional per-requester statistics are built when BRAM_ARB_STATS_EN is defined.
module bram_read_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RD_LAT  = 1
`ifdef BRAM_ARB_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         bram_addr,
  input  logic [DATA_W-1:0]         bram_dout,
  input  logic                      flush_req,
  output logic                      flush_done
`ifdef BRAM_ARB_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [NUM_REQ*CNT_W-1:0]  gnt_cnt,
  output logic [CNT_W-1:0]          conf_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int INF_W = $clog2(RD_LAT + 2);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [INF_W-1:0]   inflight;
  tag_t               tag_pipe [RD_LAT+1];
  tag_t               new_tag;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               grant_en;
  logic               grant_any;
  logic               rsp_any;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = addr[g*ADDR_W +: ADDR_W];
  end

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .index  (pick_idx),
    .any    (pick_any)
  );

  // A rising flush_req blocks grants in the very cycle it is seen, before the FSM leaves RUN.
  assign grant_en  = (state == RUN) && !flush_req;
  assign grant_any = grant_en && pick_any;
  assign gnt       = grant_en ? pick_oh : '0;

  assign new_tag.valid = grant_any;
  assign new_tag.id    = TAG_ID_W'(pick_idx);

  assign rsp_any  = tag_pipe[RD_LAT].valid;
  assign rsp_data = bram_dout;

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rsp_any && (tag_pipe[RD_LAT].id == TAG_ID_W'(i))) rsp_valid[i] = 1'b1;
    end
  end

  // Datapath: address register, round-robin pointer, tag pipeline and in-flight count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bram_addr <= '0;
      rr_ptr    <= '0;
      inflight  <= '0;
      // NOTE: the tag pipeline is a handful of flops, not a RAM, so it is reset to drop pre-reset reads.
      for (int s = 0; s <= RD_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
      tag_pipe[0] <= new_tag;
      for (int s = 1; s <= RD_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
      if (grant_any) begin
        bram_addr <= addr_arr[pick_idx];
        rr_ptr    <= (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IDX_W'(1);
      end
      unique case ({grant_any, rsp_any})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      unique case (state)
        RUN: if (flush_req) state <= DRAIN;
        DRAIN: begin
          if (inflight == '0 && !grant_any) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end
        end
        DONE: begin
          if (!flush_req) begin
            state      <= RUN;
            flush_done <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRAM_ARB_STATS_EN
  logic [CNT_W-1:0] gnt_cnt_q [NUM_REQ];
  logic             multi_req;

  assign multi_req = |(req & (req - NUM_REQ'(1)));

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign gnt_cnt[g*CNT_W +: CNT_W] = gnt_cnt_q[g];
  end

  // Saturating counters; a clear in the same cycle as an increment wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conf_cnt <= '0;
      for (int i = 0; i < NUM_REQ; i++) gnt_cnt_q[i] <= '0;
    end else if (stats_clr) begin
      conf_cnt <= '0;
      for (int i = 0; i < NUM_REQ; i++) gnt_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && gnt_cnt_q[i] != '1) gnt_cnt_q[i] <= gnt_cnt_q[i] + CNT_W'(1);
      end
      if (state == RUN && multi_req && conf_cnt != '1) conf_cnt <= conf_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
